cgr_scan: RTL and testbench
===========================

# cgr_scan

Read-back engine for the CGR count memory. After a batch of symbols has been accumulated, `cgr_scan` sweeps every CGR address in ascending order and reads the count stored there. It decodes each address back into the k-mer of 2-bit symbols that produced it, and streams {k-mer, count} records over a valid/ready interface to downstream analysis. It sits on the read port of the same memory whose write side is addressed during BC mode.

## Interface
- `K`, default 3: k-mer length, which is also the bits per axis; the address is 2K bits wide.
- `CNT_W`, default 16: count word width.
- `SKIP_ZERO`, default 1: when 1, suppress records whose count is 0.
- `CLK` input 1: single clock, rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a scan; sampled only in IDLE.
- `mem_ren` output 1: memory read enable.
- `mem_addr` output 2K: read address, `{addr_x[K-1:0], addr_y[K-1:0]}`.
- `mem_rdata` input CNT_W: read data, valid exactly 1 cycle after `mem_ren`.
- `out_valid` output 1: record available.
- `out_ready` input 1: downstream accepts the record.
- `out_kmer` output 2K: decoded symbols, oldest symbol in the MSBs.
- `out_count` output CNT_W: count for `out_kmer`.
- `busy` output 1: scan in progress.
- `done` output 1: one-cycle pulse at the end of a scan.
- `nz_total` output 2K+1: number of records emitted in the current or last scan.

## Operation
- FSM states: IDLE, READ, WAIT, OUT, DONE.
- IDLE:
  - `start`=1 → READ, with the address register cleared to 0 and `nz_total` cleared.
  - Otherwise stay in IDLE.
- READ: `mem_ren`=1 and `mem_addr`=address register; next state WAIT.
- WAIT: capture `mem_rdata` into the count register.
  - If `SKIP_ZERO`=1 and `mem_rdata`=0: if address = 2^(2K)−1 go to DONE, else increment the address and go to READ.
  - Otherwise go to OUT.
- OUT: `out_valid`=1, and the record stays stable until `out_ready`=1.
  - On the handshake, `nz_total` increments.
  - Then: if address = 2^(2K)−1 go to DONE, else increment the address and go to READ.
- DONE: `done`=1 for one cycle, then IDLE.
- Address decode: symbol i is `{addr_x[i], addr_y[i]}`. Index K−1 is the newest symbol and index 0 is the oldest.
  - `out_kmer[2K-1:2K-2]` = symbol 0, and so on down to `out_kmer[1:0]` = symbol K−1.
- `busy`=1 in every state except IDLE.
- `start` outside IDLE is ignored; no queuing.
- The address counter is 2K bits and never wraps inside a scan. The terminal compare happens before the increment.
- `nz_total` saturates at 2^(2K), which is reachable only when every entry is emitted. It holds its value after DONE until the next `start`.

## Timing
- Reset (`RST_N`=0, at any time including mid-scan): state IDLE. `mem_ren`, `mem_addr`, `out_valid`, `out_kmer`, `out_count`, `busy`, `done` and `nz_total` are all 0. Any record in flight is dropped.
- `start` sampled high at edge 0 → `mem_ren`=1 with `mem_addr`=0 during cycle 1. Data is captured at the end of cycle 2. `out_valid` rises in cycle 3.
- Per-address cost:
  - 2 cycles for a skipped entry.
  - 3 + (stall cycles) for an emitted entry.
- All-zero memory with `SKIP_ZERO`=1: `done` is high exactly 2·2^(2K)+1 cycles after the `start` edge. For K=3 that is cycle 129.
- `mem_ren` is never high in WAIT, OUT or DONE, so at most one read is outstanding.
- `out_valid` never drops without a handshake, and `out_kmer`/`out_count` do not change while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `cgr_pkg`:
  - the 2-bit symbol encoding constants shared with the write side (`{a,b}` = `{x bit, y bit}`);
  - the FSM state enum;
  - the default K and CNT_W.
- One sub-module, `cgr_addr_decode`: purely combinational, mapping a 2K-bit address to a 2K-bit k-mer. It is reused by the test bench model.

## Test plan
- Reset release with memory preloaded, then `start` pulse: `mem_addr` steps 0..63 and `done` pulses once; `nz_total` equals the number of nonzero entries.
- Decode check: a single entry at addr 6'b100_010 (x=100, y=010) holds count 5, everything else is 0 → exactly one record with `out_kmer`=6'b00_01_10 and `out_count`=5.
- Backpressure: `out_ready` held low 10 cycles on the first record → `out_valid` stays high and the record is stable; no `mem_ren` pulses occur during the stall.
- `SKIP_ZERO`=0, all-zero memory → 64 records, all with `out_count`=0, and `nz_total`=64.
- `start` pulsed again mid-scan → ignored; the scan completes normally with a single `done`.
- `RST_N` asserted during OUT at addr 20 → all outputs are 0 immediately. A later `start` restarts at addr 0 with `nz_total`=0.

Source files
------------

// File: rtl/cgr_pkg.sv
// Shared definitions for the CGR count-memory read-back path: symbol encoding,
// scan FSM states and default geometry.
package cgr_pkg;

    localparam int unsigned DefaultK    = 3;
    localparam int unsigned DefaultCntW = 16;

    // Symbol encoding {x bit, y bit}, identical to the write side.
    localparam logic [1:0] SymA = 2'b00;
    localparam logic [1:0] SymC = 2'b01;
    localparam logic [1:0] SymG = 2'b10;
    localparam logic [1:0] SymT = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StOut,
        StDone
    } scan_state_e;

endpackage

// File: rtl/cgr_scan_if.sv
// Memory read port plus record stream of the CGR scan engine.
interface cgr_scan_if
    import cgr_pkg::*;
#(
    parameter int unsigned K     = DefaultK,
    parameter int unsigned CNT_W = DefaultCntW
);
    logic               mem_ren;
    logic [2*K-1:0]     mem_addr;
    logic [CNT_W-1:0]   mem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [2*K-1:0]     out_kmer;
    logic [CNT_W-1:0]   out_count;

    modport master (
        output mem_ren, mem_addr, out_valid, out_kmer, out_count,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_ren, mem_addr, out_valid, out_kmer, out_count,
        output mem_rdata, out_ready
    );

endinterface

// File: rtl/cgr_addr_decode.sv
// Maps a CGR address {x, y} back to its k-mer; bit i of each axis forms symbol i,
// with symbol 0 (oldest) placed in the MSBs.
module cgr_addr_decode
    import cgr_pkg::*;
#(
    parameter int unsigned K = DefaultK
) (
    input  logic [2*K-1:0] addr,
    output logic [2*K-1:0] kmer
);

    always_comb begin
        kmer = '0;
        for (int unsigned i = 0; i < K; i++) begin
            kmer[2*(K-1-i) +: 2] = {addr[K+i], addr[i]};
        end
    end

endmodule

// File: rtl/cgr_scan.sv
// Sweeps every CGR address in ascending order, reads its count and streams
// {k-mer, count} records over a valid/ready interface.
module cgr_scan
    import cgr_pkg::*;
#(
    parameter int unsigned K         = DefaultK,
    parameter int unsigned CNT_W     = DefaultCntW,
    parameter bit          SKIP_ZERO = 1'b1
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           start,
    cgr_scan_if.master     bus,
    output logic           busy,
    output logic           done,
    output logic [2*K:0]   nz_total
);

    localparam int unsigned AW       = 2 * K;
    localparam logic [AW-1:0] LastAddr = '1;
    localparam logic [AW-1:0] AddrOne  = 1;
    localparam logic [AW:0]   NzOne    = 1;
    localparam logic [AW:0]   NzMax    = {1'b1, {AW{1'b0}}};

    scan_state_e      state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW:0]      nz_q, nz_d;
    logic [AW-1:0]    kmer;

    cgr_addr_decode #(
        .K (K)
    ) u_decode (
        .addr (addr_q),
        .kmer (kmer)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            nz_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            nz_q    <= nz_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        nz_d          = nz_q;
        bus.mem_ren   = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    state_d = StRead;
                    addr_d  = '0;
                    nz_d    = '0;
                end
            end
            StRead: begin
                bus.mem_ren = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                cnt_d = bus.mem_rdata;
                if (SKIP_ZERO && (bus.mem_rdata == '0)) begin
                    // Terminal compare before increment: the counter never wraps.
                    if (addr_q == LastAddr) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + AddrOne;
                        state_d = StRead;
                    end
                end else begin
                    state_d = StOut;
                end
            end
            StOut: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (nz_q != NzMax) begin
                        nz_d = nz_q + NzOne;
                    end
                    if (addr_q == LastAddr) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + AddrOne;
                        state_d = StRead;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.out_kmer  = kmer;
    assign bus.out_count = cnt_q;
    assign nz_total      = nz_q;

endmodule

// File: tb/tb_cgr_scan.sv
// Bench for cgr_scan: decode vector table, randomized scans against a memory-level
// reference model, plus backpressure, restart-ignore, no-skip and mid-scan reset cases.
module tb_cgr_scan;
    import cgr_pkg::*;

    localparam int unsigned K  = DefaultK;
    localparam int unsigned CW = DefaultCntW;
    localparam int unsigned AW = 2 * K;
    localparam int          N  = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] kmer;
        logic [CW-1:0] cnt;
    } rec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] cnt;
        logic [AW-1:0] kmer;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        ready = 1'b1;
    logic        busy0, done0, busy1, done1;
    logic [AW:0] nz0, nz1;

    cgr_scan_if #(.K(K), .CNT_W(CW)) bus0 ();
    cgr_scan_if #(.K(K), .CNT_W(CW)) bus1 ();

    cgr_scan #(.K(K), .CNT_W(CW), .SKIP_ZERO(1'b1)) dut0 (
        .CLK (CLK), .RST_N (RST_N), .start (start0), .bus (bus0),
        .busy (busy0), .done (done0), .nz_total (nz0)
    );

    cgr_scan #(.K(K), .CNT_W(CW), .SKIP_ZERO(1'b0)) dut1 (
        .CLK (CLK), .RST_N (RST_N), .start (start1), .bus (bus1),
        .busy (busy1), .done (done1), .nz_total (nz1)
    );

    always #5 CLK = ~CLK;

    // Count memory with one-cycle read latency.
    logic [CW-1:0] mem [N];
    always @(posedge CLK) begin
        if (bus0.mem_ren) bus0.mem_rdata <= mem[bus0.mem_addr];
        if (bus1.mem_ren) bus1.mem_rdata <= mem[bus1.mem_addr];
    end
    assign bus0.out_ready = ready;
    assign bus1.out_ready = ready;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference decode from the address rules: symbol i = {x[i], y[i]}, symbol 0 first.
    function automatic logic [AW-1:0] kdec(input int unsigned a);
        int unsigned x = a / (1 << K);
        int unsigned y = a % (1 << K);
        int unsigned r = 0;
        for (int i = 0; i < int'(K); i++) begin
            r = r * 4 + ((x >> i) & 1) * 2 + ((y >> i) & 1);
        end
        return AW'(r);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_mem_ren"}, bus0.mem_ren, 0);
        check({tag, "_mem_addr"}, bus0.mem_addr, 0);
        check({tag, "_out_valid"}, bus0.out_valid, 0);
        check({tag, "_out_kmer"}, bus0.out_kmer, 0);
        check({tag, "_out_count"}, bus0.out_count, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_nz_total"}, nz0, 0);
    endtask

    int            done_at, valid_at, stall_ren, done_cnt, nz_first;
    logic          ren_first;
    logic [AW-1:0] addr_first;
    rec_t          got0[$];
    logic [AW-1:0] addrs0[$];

    // Runs one scan on dut0; observation happens 1 time unit after each rising edge.
    task automatic scan0(input int stall, input bit rnd, input int mid);
        bit   pv, pr;
        rec_t prec, cur;
        int   n, left;
        got0.delete();
        addrs0.delete();
        done_at = -1; valid_at = -1; stall_ren = 0; done_cnt = 0;
        left = stall; pv = 1'b0; pr = 1'b1; prec = '0;
        ready = 1'b1;
        start0 = 1'b1;
        @(posedge CLK); #1;
        start0 = 1'b0;
        n = 1;
        while (n < 3000) begin
            cur = '{kmer: bus0.out_kmer, cnt: bus0.out_count};
            if (n == 1) begin
                ren_first  = bus0.mem_ren;
                addr_first = bus0.mem_addr;
                nz_first   = int'(nz0);
            end
            if (pv && !pr) begin
                check("hold_valid", bus0.out_valid, 1);
                check("hold_record", cur, prec);
            end
            if (bus0.mem_ren) addrs0.push_back(bus0.mem_addr);
            if (done0) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (bus0.out_valid && valid_at < 0) valid_at = n;
            if (bus0.out_valid && left > 0) begin
                ready = 1'b0;
                left--;
                if (bus0.mem_ren) stall_ren++;
            end else begin
                ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            start0 = (n == mid);
            if (bus0.out_valid && ready) got0.push_back(cur);
            pv = bus0.out_valid; pr = ready; prec = cur;
            if (done_at >= 0 && n >= done_at + 3) break;
            @(posedge CLK); #1;
            n++;
        end
        ready = 1'b1;
        start0 = 1'b0;
        check("scan_done_seen", done_at >= 0, 1);
    endtask

    task automatic run_check0(input string tag, input int stall, input bit rnd, input int mid);
        rec_t exp[$];
        int   bad, first;
        first = -1;
        for (int a = 0; a < N; a++) begin
            if (mem[a] != '0) begin
                exp.push_back('{kmer: kdec(a), cnt: mem[a]});
                if (first < 0) first = a;
            end
        end
        scan0(stall, rnd, mid);
        check({tag, "_nrec"}, got0.size(), exp.size());
        bad = 0;
        foreach (exp[i]) if (i >= got0.size() || got0[i] !== exp[i]) bad++;
        check({tag, "_records"}, bad, 0);
        bad = 0;
        for (int i = 0; i < N; i++) if (i >= addrs0.size() || addrs0[i] !== AW'(i)) bad++;
        check({tag, "_naddr"}, addrs0.size(), N);
        check({tag, "_addrseq"}, bad, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_nz_total"}, nz0, exp.size());
        check({tag, "_ren_first"}, ren_first, 1);
        check({tag, "_addr_first"}, addr_first, 0);
        check({tag, "_nz_cleared"}, nz_first, 0);
        check({tag, "_busy_end"}, busy0, 0);
        check({tag, "_stall_ren"}, stall_ren, 0);
        if (!rnd) begin
            check({tag, "_done_at"}, done_at, 1 + 2 * N + exp.size() + stall);
            if (first >= 0) check({tag, "_valid_at"}, valid_at, 3 + 2 * first);
        end
    endtask

    vec_t vecs[8];
    rec_t r0;
    int   n1, recs, nzc, kbad, d1, d1_at;
    bit   found;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{addr: 6'b100_010, cnt: 16'd5,    kmer: 6'b00_01_10};
        vecs[1] = '{addr: 6'b000_000, cnt: 16'd1,    kmer: 6'b00_00_00};
        vecs[2] = '{addr: 6'b111_111, cnt: 16'hffff, kmer: 6'b11_11_11};
        vecs[3] = '{addr: 6'b001_000, cnt: 16'd7,    kmer: 6'b10_00_00};
        vecs[4] = '{addr: 6'b000_001, cnt: 16'd9,    kmer: 6'b01_00_00};
        vecs[5] = '{addr: 6'b100_000, cnt: 16'd300,  kmer: 6'b00_00_10};
        vecs[6] = '{addr: 6'b000_100, cnt: 16'd2,    kmer: 6'b00_00_01};
        vecs[7] = '{addr: 6'b011_110, cnt: 16'h8000, kmer: 6'b10_11_01};

        for (int a = 0; a < N; a++) mem[a] = '0;
        #1;
        check_reset("reset0");
        check("reset0_busy1", busy1, 0);
        check("reset0_nz1", nz1, 0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        // Single-entry decode table.
        foreach (vecs[v]) begin
            for (int a = 0; a < N; a++) mem[a] = '0;
            mem[vecs[v].addr] = vecs[v].cnt;
            scan0(0, 1'b0, -1);
            r0 = (got0.size() > 0) ? got0[0] : '1;
            check("vec_nrec", got0.size(), 1);
            check("vec_kmer", r0.kmer, vecs[v].kmer);
            check("vec_count", r0.cnt, vecs[v].cnt);
            check("vec_nz_total", nz0, 1);
            check("vec_done_at", done_at, 2 * N + 2);
            check("vec_valid_at", valid_at, 3 + 2 * int'(vecs[v].addr));
        end

        for (int a = 0; a < N; a++) mem[a] = '0;
        run_check0("allzero", 0, 1'b0, -1);

        for (int t = 0; t < 3; t++) begin
            for (int a = 0; a < N; a++) mem[a] = $urandom_range(0, 1) ? CW'($urandom) : '0;
            run_check0("random", 0, 1'b1, -1);
        end

        for (int a = 0; a < N; a++) mem[a] = $urandom_range(0, 1) ? CW'($urandom) : '0;
        mem[0] = 16'd42;
        run_check0("stall", 10, 1'b0, -1);

        for (int a = 0; a < N; a++) mem[a] = CW'($urandom_range(1, 65535));
        run_check0("midstart", 0, 1'b0, 50);

        // No-skip instance over all-zero memory.
        for (int a = 0; a < N; a++) mem[a] = '0;
        ready = 1'b1;
        start1 = 1'b1;
        @(posedge CLK); #1;
        start1 = 1'b0;
        n1 = 1; recs = 0; nzc = 0; kbad = 0; d1 = 0; d1_at = -1;
        while (n1 < 1000) begin
            if (bus1.out_valid) begin
                if (bus1.out_kmer !== kdec(recs)) kbad++;
                if (bus1.out_count !== '0) nzc++;
                recs++;
            end
            if (done1) begin
                d1++;
                if (d1_at < 0) d1_at = n1;
            end
            if (d1_at >= 0 && n1 >= d1_at + 3) break;
            @(posedge CLK); #1;
            n1++;
        end
        check("noskip_nrec", recs, N);
        check("noskip_counts", nzc, 0);
        check("noskip_kmers", kbad, 0);
        check("noskip_nz_total", nz1, N);
        check("noskip_done_cnt", d1, 1);
        check("noskip_done_at", d1_at, 1 + 3 * N);

        // Asynchronous reset while presenting the record at address 20.
        for (int a = 0; a < N; a++) mem[a] = CW'($urandom_range(1, 65535));
        ready = 1'b1;
        start0 = 1'b1;
        @(posedge CLK); #1;
        start0 = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            if (bus0.out_valid && bus0.mem_addr == AW'(20)) found = 1'b1;
            else begin
                @(posedge CLK); #1;
            end
        end
        check("rst_reach_addr20", found, 1);
        ready = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        check_reset("rst_mid");
        @(posedge CLK); #1;
        RST_N = 1'b1;
        ready = 1'b1;
        @(posedge CLK); #1;
        check("rst_idle_busy", busy0, 0);
        run_check0("after_rst", 0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
